av_bus_arbiter_2m: RTL and testbench

- Two-master, one-slave arbiter for the CPU's Avalon-style word buses. It shares a single slave port, such as the boot ROM, user flash controller or peripheral bus, between the DBus master (M0) and the IBus master (M1).
- Grant is round-robin by default, or fixed priority to M0.
- The block holds the grant until the slave completes the transfer; the non-granted master is stalled via its wait-request.
- Single beat only; burst count to the slave is constant 1.

---
 rtl/av_bus_arbiter_2m.sv | 149 ++++++++++++++
 tb/tb_av_bus_arbiter_2m.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/av_bus_arbiter_2m.sv
// Two-master, one-slave arbiter for Avalon-style single-beat word buses.
// M0 (DBus) and M1 (IBus) share one slave. The grant is held until the slave
// completes the transfer; the non-granted master is stalled via wait-request.
//
// Ports:
//   i_Clk, i_nReset           clock, asynchronous active-low reset
//   i_Mx_* / o_Mx_*           master x request inputs, read data and stall
//   o_S_* / i_S_*             shared slave port (burst count fixed at 1)
//   o_Grant                   one-hot current grant {M1,M0}; 00 = idle
module av_bus_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                    i_Clk,
    input  logic                    i_nReset,

    input  logic [ADDR_WIDTH-1:0]   i_M0_Addr,
    input  logic [DATA_WIDTH/8-1:0] i_M0_ByteEn,
    input  logic                    i_M0_Read,
    input  logic                    i_M0_Write,
    input  logic [DATA_WIDTH-1:0]   i_M0_WriteData,
    output logic [DATA_WIDTH-1:0]   o_M0_ReadData,
    output logic                    o_M0_WaitRequest,

    input  logic [ADDR_WIDTH-1:0]   i_M1_Addr,
    input  logic [DATA_WIDTH/8-1:0] i_M1_ByteEn,
    input  logic                    i_M1_Read,
    input  logic                    i_M1_Write,
    input  logic [DATA_WIDTH-1:0]   i_M1_WriteData,
    output logic [DATA_WIDTH-1:0]   o_M1_ReadData,
    output logic                    o_M1_WaitRequest,

    output logic [ADDR_WIDTH-1:0]   o_S_Addr,
    output logic [DATA_WIDTH/8-1:0] o_S_ByteEn,
    output logic                    o_S_Read,
    output logic                    o_S_Write,
    output logic [DATA_WIDTH-1:0]   o_S_WriteData,
    output logic [7:0]              o_S_BurstCount,
    input  logic [DATA_WIDTH-1:0]   i_S_ReadData,
    input  logic                    i_S_WaitRequest,

    output logic [1:0]              o_Grant
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_m1;        // 1 = M1 was served last, so M0 wins the next tie
    logic   last_m1_next;

    logic   req0;
    logic   req1;

    assign req0 = i_M0_Read | i_M0_Write;
    assign req1 = i_M1_Read | i_M1_Write;

    // State register; reset leaves M1 as last-served so M0 wins first.
    always_ff @(posedge i_Clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_next;
            last_m1 <= last_m1_next;
        end
    end

    // Next-state: arbitrate in IDLE, hold grant until completion or request drop.
    always_comb begin
        state_next   = state;
        last_m1_next = last_m1;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    if (FIXED_PRIORITY || last_m1) state_next = GNT_M0;
                    else                           state_next = GNT_M1;
                end else if (req0) begin
                    state_next = GNT_M0;
                end else if (req1) begin
                    state_next = GNT_M1;
                end
            end
            GNT_M0: begin
                // A dropped request abandons the grant without counting as service.
                if (!req0) begin
                    state_next = IDLE;
                end else if (!i_S_WaitRequest) begin
                    state_next   = IDLE;
                    last_m1_next = 1'b0;
                end
            end
            GNT_M1: begin
                if (!req1) begin
                    state_next = IDLE;
                end else if (!i_S_WaitRequest) begin
                    state_next   = IDLE;
                    last_m1_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: slave port muxed from the granted master; write wins over read.
    always_comb begin
        o_S_Addr         = '0;
        o_S_ByteEn       = BE_WIDTH'(0);
        o_S_Read         = 1'b0;
        o_S_Write        = 1'b0;
        o_S_WriteData    = '0;
        o_M0_WaitRequest = 1'b1;
        o_M1_WaitRequest = 1'b1;
        o_Grant          = 2'b00;
        case (state)
            GNT_M0: begin
                o_S_Addr         = i_M0_Addr;
                o_S_ByteEn       = i_M0_ByteEn;
                o_S_Write        = i_M0_Write;
                o_S_Read         = i_M0_Read & ~i_M0_Write;
                o_S_WriteData    = i_M0_WriteData;
                o_M0_WaitRequest = i_S_WaitRequest;
                o_Grant          = 2'b01;
            end
            GNT_M1: begin
                o_S_Addr         = i_M1_Addr;
                o_S_ByteEn       = i_M1_ByteEn;
                o_S_Write        = i_M1_Write;
                o_S_Read         = i_M1_Read & ~i_M1_Write;
                o_S_WriteData    = i_M1_WriteData;
                o_M1_WaitRequest = i_S_WaitRequest;
                o_Grant          = 2'b10;
            end
            default: ;
        endcase
    end

    assign o_S_BurstCount = 8'd1;
    assign o_M0_ReadData  = i_S_ReadData;
    assign o_M1_ReadData  = i_S_ReadData;

endmodule

// File: tb/tb_av_bus_arbiter_2m.sv
// Directed testbench for av_bus_arbiter_2m: a round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_av_bus_arbiter_2m;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] m0_addr,  m1_addr;
    logic [BW-1:0] m0_be,    m1_be;
    logic          m0_read,  m1_read;
    logic          m0_write, m1_write;
    logic [DW-1:0] m0_wd,    m1_wd;
    logic [DW-1:0] s_rd;
    logic          s_wait;

    // round-robin instance outputs
    logic [DW-1:0] m0_rd, m1_rd;
    logic          m0_wr, m1_wr;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_be;
    logic          s_read, s_write;
    logic [DW-1:0] s_wd;
    logic [7:0]    s_bc;
    logic [1:0]    grant;

    // fixed-priority instance outputs
    logic [DW-1:0] fp_m0_rd, fp_m1_rd;
    logic          fp_m0_wr, fp_m1_wr;
    logic [AW-1:0] fp_s_addr;
    logic [BW-1:0] fp_s_be;
    logic          fp_s_read, fp_s_write;
    logic [DW-1:0] fp_s_wd;
    logic [7:0]    fp_s_bc;
    logic [1:0]    fp_grant;

    int checks = 0;
    int passed = 0;

    av_bus_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) dut (
        .i_Clk(clk), .i_nReset(rst_n),
        .i_M0_Addr(m0_addr), .i_M0_ByteEn(m0_be), .i_M0_Read(m0_read), .i_M0_Write(m0_write),
        .i_M0_WriteData(m0_wd), .o_M0_ReadData(m0_rd), .o_M0_WaitRequest(m0_wr),
        .i_M1_Addr(m1_addr), .i_M1_ByteEn(m1_be), .i_M1_Read(m1_read), .i_M1_Write(m1_write),
        .i_M1_WriteData(m1_wd), .o_M1_ReadData(m1_rd), .o_M1_WaitRequest(m1_wr),
        .o_S_Addr(s_addr), .o_S_ByteEn(s_be), .o_S_Read(s_read), .o_S_Write(s_write),
        .o_S_WriteData(s_wd), .o_S_BurstCount(s_bc), .i_S_ReadData(s_rd),
        .i_S_WaitRequest(s_wait), .o_Grant(grant)
    );

    av_bus_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) dut_fp (
        .i_Clk(clk), .i_nReset(rst_n),
        .i_M0_Addr(m0_addr), .i_M0_ByteEn(m0_be), .i_M0_Read(m0_read), .i_M0_Write(m0_write),
        .i_M0_WriteData(m0_wd), .o_M0_ReadData(fp_m0_rd), .o_M0_WaitRequest(fp_m0_wr),
        .i_M1_Addr(m1_addr), .i_M1_ByteEn(m1_be), .i_M1_Read(m1_read), .i_M1_Write(m1_write),
        .i_M1_WriteData(m1_wd), .o_M1_ReadData(fp_m1_rd), .o_M1_WaitRequest(fp_m1_wr),
        .o_S_Addr(fp_s_addr), .o_S_ByteEn(fp_s_be), .o_S_Read(fp_s_read), .o_S_Write(fp_s_write),
        .o_S_WriteData(fp_s_wd), .o_S_BurstCount(fp_s_bc), .i_S_ReadData(s_rd),
        .i_S_WaitRequest(s_wait), .o_Grant(fp_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_addr = '0; m0_be = '0; m0_read = 1'b0; m0_write = 1'b0; m0_wd = '0;
        m1_addr = '0; m1_be = '0; m1_read = 1'b0; m1_write = 1'b0; m1_wd = '0;
        s_rd = '0; s_wait = 1'b0;
    endtask

    // Leaves the bench just after a clock edge with both DUTs in IDLE.
    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        m0_read = 1'b1; m0_addr = 30'h0000_0040;
        m1_read = 1'b1; m1_addr = 30'h0000_0080;
        #1;
        checks++; if (s_read !== 1'b0)   $display("FAIL rst_s_read: got %b expected 0", s_read);   else passed++;
        checks++; if (s_write !== 1'b0)  $display("FAIL rst_s_write: got %b expected 0", s_write); else passed++;
        checks++; if (m0_wr !== 1'b1)    $display("FAIL rst_m0_wait: got %b expected 1", m0_wr);   else passed++;
        checks++; if (m1_wr !== 1'b1)    $display("FAIL rst_m1_wait: got %b expected 1", m1_wr);   else passed++;
        checks++; if (grant !== 2'b00)   $display("FAIL rst_grant: got %b expected 00", grant);    else passed++;
        checks++; if (s_bc !== 8'd1)     $display("FAIL rst_burst: got %0d expected 1", s_bc);     else passed++;
        checks++; if (s_addr !== 30'h0)  $display("FAIL rst_s_addr: got %h expected 0", s_addr);   else passed++;
        next_cycle();
        checks++; if (grant !== 2'b00)   $display("FAIL rst_hold_grant: got %b expected 00", grant); else passed++;
        rst_n = 1'b1;
        next_cycle();
        checks++; if (grant !== 2'b01)   $display("FAIL rst_first_grant: got %b expected 01", grant); else passed++;
        checks++; if (s_addr !== 30'h0000_0040) $display("FAIL rst_first_addr: got %h expected 0000040", s_addr); else passed++;
        clear_inputs();
    endtask

    task automatic test_single_read();
        apply_reset();
        // cycle 0: request seen in IDLE, not forwarded yet
        m1_read = 1'b1; m1_addr = 30'h0020_0000; s_wait = 1'b1;
        #1;
        checks++; if (s_read !== 1'b0)   $display("FAIL rd_c0_s_read: got %b expected 0", s_read); else passed++;
        checks++; if (m1_wr !== 1'b1)    $display("FAIL rd_c0_m1_wait: got %b expected 1", m1_wr); else passed++;
        // cycles 1..2: slave stalls
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            checks++; if (s_read !== 1'b1) $display("FAIL rd_c%0d_s_read: got %b expected 1", c, s_read); else passed++;
            checks++; if (m1_wr !== 1'b1)  $display("FAIL rd_c%0d_m1_wait: got %b expected 1", c, m1_wr); else passed++;
            checks++; if (grant !== 2'b10) $display("FAIL rd_c%0d_grant: got %b expected 10", c, grant); else passed++;
            checks++; if (s_addr !== 30'h0020_0000) $display("FAIL rd_c%0d_addr: got %h expected 0200000", c, s_addr); else passed++;
        end
        // cycle 3: completion
        next_cycle();
        s_wait = 1'b0; s_rd = 32'hDEAD_BEEF;
        #1;
        checks++; if (s_read !== 1'b1)   $display("FAIL rd_c3_s_read: got %b expected 1", s_read); else passed++;
        checks++; if (m1_wr !== 1'b0)    $display("FAIL rd_c3_m1_wait: got %b expected 0", m1_wr); else passed++;
        checks++; if (m0_wr !== 1'b1)    $display("FAIL rd_c3_m0_wait: got %b expected 1", m0_wr); else passed++;
        checks++; if (m1_rd !== 32'hDEAD_BEEF) $display("FAIL rd_c3_data: got %h expected deadbeef", m1_rd); else passed++;
        // cycle 4: back to idle
        next_cycle();
        m1_read = 1'b0;
        #1;
        checks++; if (grant !== 2'b00)   $display("FAIL rd_c4_grant: got %b expected 00", grant); else passed++;
        checks++; if (s_read !== 1'b0)   $display("FAIL rd_c4_s_read: got %b expected 0", s_read); else passed++;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [8];
        int xfers;
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        xfers = 0;
        apply_reset();
        m0_read = 1'b1; m0_addr = 30'h0000_0100;
        m1_read = 1'b1; m1_addr = 30'h0000_0200;
        s_wait  = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            checks++; if (grant !== exp_g[c]) $display("FAIL rr_c%0d_grant: got %b expected %b", c, grant, exp_g[c]); else passed++;
            if ((grant == 2'b01 && !m0_wr) || (grant == 2'b10 && !m1_wr)) xfers++;
        end
        checks++; if (xfers != 4) $display("FAIL rr_xfers: got %0d expected 4", xfers); else passed++;
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        m0_read = 1'b1; m0_addr = 30'h0000_0300;
        m1_read = 1'b1; m1_addr = 30'h0000_0400;
        s_wait  = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            checks++;
            if (fp_grant !== ((c % 2 == 1) ? 2'b01 : 2'b00))
                $display("FAIL fp_c%0d_grant: got %b expected %b", c, fp_grant, (c % 2 == 1) ? 2'b01 : 2'b00);
            else passed++;
            checks++; if (fp_m1_wr !== 1'b1) $display("FAIL fp_c%0d_m1_wait: got %b expected 1", c, fp_m1_wr); else passed++;
        end
        clear_inputs();
    endtask

    task automatic test_write_byte_enables();
        apply_reset();
        m0_write = 1'b1; m0_addr = 30'h0000_0123; m0_be = 4'b0010; m0_wd = 32'h1122_3344;
        s_wait   = 1'b1;
        #1;
        checks++; if (s_write !== 1'b0) $display("FAIL wr_c0_s_write: got %b expected 0", s_write); else passed++;
        next_cycle();
        checks++; if (s_write !== 1'b1) $display("FAIL wr_c1_s_write: got %b expected 1", s_write); else passed++;
        checks++; if (s_read !== 1'b0)  $display("FAIL wr_c1_s_read: got %b expected 0", s_read); else passed++;
        checks++; if (s_addr !== 30'h0000_0123) $display("FAIL wr_c1_addr: got %h expected 0000123", s_addr); else passed++;
        checks++; if (s_be !== 4'b0010) $display("FAIL wr_c1_be: got %b expected 0010", s_be); else passed++;
        checks++; if (s_wd !== 32'h1122_3344) $display("FAIL wr_c1_wdata: got %h expected 11223344", s_wd); else passed++;
        checks++; if (m0_wr !== 1'b1)   $display("FAIL wr_c1_m0_wait: got %b expected 1", m0_wr); else passed++;
        next_cycle();
        s_wait = 1'b0;
        #1;
        checks++; if (s_write !== 1'b1) $display("FAIL wr_c2_s_write: got %b expected 1", s_write); else passed++;
        checks++; if (m0_wr !== 1'b0)   $display("FAIL wr_c2_m0_wait: got %b expected 0", m0_wr); else passed++;
        // illegal read+write together: write must reach the slave
        next_cycle();
        m0_read = 1'b1; m0_write = 1'b1;
        #1;
        checks++; if (s_write !== 1'b0) $display("FAIL wr_c3_idle_write: got %b expected 0", s_write); else passed++;
        checks++; if (s_be !== 4'b0000) $display("FAIL wr_c3_idle_be: got %b expected 0000", s_be); else passed++;
        next_cycle();
        checks++; if (s_write !== 1'b1) $display("FAIL wr_rw_s_write: got %b expected 1", s_write); else passed++;
        checks++; if (s_read !== 1'b0)  $display("FAIL wr_rw_s_read: got %b expected 0", s_read); else passed++;
        clear_inputs();
    endtask

    task automatic test_dropped_request();
        apply_reset();
        m0_read = 1'b1; m0_addr = 30'h0000_0500; s_wait = 1'b1;
        next_cycle();
        checks++; if (grant !== 2'b01) $display("FAIL drop_grant: got %b expected 01", grant); else passed++;
        next_cycle();
        m0_read = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0) $display("FAIL drop_s_read: got %b expected 0", s_read); else passed++;
        next_cycle();
        m0_read = 1'b1; m1_read = 1'b1; s_wait = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) $display("FAIL drop_idle: got %b expected 00", grant); else passed++;
        // abandoned grant does not count as service, so M0 still wins the tie
        next_cycle();
        checks++; if (grant !== 2'b01) $display("FAIL drop_regrant: got %b expected 01", grant); else passed++;
        clear_inputs();
    endtask

    task automatic test_mid_transfer_reset();
        apply_reset();
        m1_read = 1'b1; m1_addr = 30'h0000_0600; s_wait = 1'b1;
        next_cycle();
        checks++; if (s_read !== 1'b1) $display("FAIL mrst_pre_s_read: got %b expected 1", s_read); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_read !== 1'b0) $display("FAIL mrst_s_read: got %b expected 0", s_read); else passed++;
        checks++; if (grant !== 2'b00) $display("FAIL mrst_grant: got %b expected 00", grant); else passed++;
        checks++; if (m1_wr !== 1'b1)  $display("FAIL mrst_m1_wait: got %b expected 1", m1_wr); else passed++;
        m1_read = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            checks++; if (grant !== 2'b00) $display("FAIL mrst_after%0d_grant: got %b expected 00", c, grant); else passed++;
            checks++; if (s_read !== 1'b0) $display("FAIL mrst_after%0d_s_read: got %b expected 0", c, s_read); else passed++;
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_write_byte_enables();
        test_dropped_request();
        test_mid_transfer_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
